// File: rtl/fifo_rd_stream.sv
// Read-domain consumer for the async FIFO: pops words into a 3-entry skid buffer
// and presents them as a valid/ready stream framed into fixed-length bursts.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 12,
  parameter int BURST_LEN = 4,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 enable,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_SIZE-1:0]  word_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t               state;
  logic [DATA_SIZE-1:0] mem [3];
  logic [1:0]           head, tail, occ;
  logic                 inflight;
  logic [7:0]           beat;
  logic [2:0]           pend;
  logic                 wr, rd;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pending = words already buffered plus the one whose data lands next edge;
  // gating pops on it keeps rinc independent of out_ready.
  assign pend      = {1'b0, occ} + {2'b00, inflight};
  assign wr        = inflight;
  assign rd        = out_valid & out_ready;
  assign rinc      = (state == RUN) & ~rEmpty & (pend < 3'd3);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[head];
  assign out_last  = out_valid & (beat == LAST_BEAT);
  assign busy      = (state != IDLE);

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      state      <= IDLE;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      head       <= 2'd0;
      tail       <= 2'd0;
      beat       <= 8'd0;
      word_count <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight <= rinc;
      if (wr) begin
        mem[tail] <= rData;
        tail      <= nxt(tail);
      end
      if (rd) begin
        head       <= nxt(head);
        word_count <= word_count + CNT_SIZE'(1);
        beat       <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
      end
      case ({wr, rd})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= (pend != 3'd0) ? DRAIN : IDLE;
        // Re-enable wins over finishing the drain.
        DRAIN:   if (enable) state <= RUN;
                 else if (pend == 3'd0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
